// File: rtl/bmp_pkg.sv
// Shared constants, FSM encoding and helpers for the BMP output sink.
package bmp_pkg;

    localparam int HDR_BYTES_DFLT = 56;

    // Stream byte offsets carrying the little-endian 32-bit file size.
    localparam int FS_OFS_LO = 2;
    localparam int FS_OFS_HI = 5;

    localparam int ERR_HDR   = 0;
    localparam int ERR_SHORT = 1;
    localparam int ERR_SRC   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_BODY,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // A file shorter than its own header still has the full header forwarded.
    function automatic logic [31:0] frame_target(input logic [31:0] fsize, input logic [31:0] hdr);
        return (fsize < hdr) ? hdr : fsize;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fall-through FIFO: the head entry is visible while not empty.
module sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; the consumer masks the head while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/bmp_master_sink.sv
// Consumes the scheduler's BMP word stream, buffers it and writes it word by
// word into the output frame memory with trimmed byte enables on the last word.
module bmp_master_sink
    import bmp_pkg::*;
#(
    parameter int DATA_BUS_SIZE = 32,
    parameter int ADDR_W        = 16,
    parameter int FIFO_DEPTH    = 4,
    parameter int HDR_BYTES     = HDR_BYTES_DFLT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [1:0]                   in_valid,
    input  logic [DATA_BUS_SIZE-1:0]     in_data,
    input  logic                         in_cmplt,
    output logic                         in_ready,
    output logic                         mem_req,
    input  logic                         mem_gnt,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_BUS_SIZE-1:0]     mem_data,
    output logic [DATA_BUS_SIZE/8-1:0]   mem_be,
    output logic [31:0]                  file_size,
    output logic                         src_id,
    output logic                         frame_done,
    output logic [2:0]                   err
);
    localparam int          BPW        = DATA_BUS_SIZE / 8;
    localparam int          ENTRY_W    = DATA_BUS_SIZE + BPW;
    localparam int          CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] HDR_LEN    = 32'(HDR_BYTES);
    localparam logic [31:0] WORD_BYTES = 32'(BPW);

    state_e             state_q, state_d;
    logic [31:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]        file_size_q, file_size_d;
    logic               src_id_q, src_id_d;
    logic [2:0]         err_q, err_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               live_q;

    logic               accept, push, pop;
    logic               hdr_word, body_word, hdr_done, frame_met;
    logic [31:0]        cnt_base, cnt_next, remaining, target;
    logic [BPW-1:0]     push_be;

    logic [ENTRY_W-1:0] fifo_head;
    logic               fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i ({push_be, in_data}),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // live_q holds in_ready low until the first clock after reset release.
    assign in_ready = live_q && (state_q inside {ST_IDLE, ST_HEADER, ST_BODY})
                      && (fifo_count < CNT_W'(FIFO_DEPTH));
    assign accept   = in_valid[0] && in_ready;
    assign mem_req  = !fifo_empty;
    assign pop      = mem_req && mem_gnt;
    assign {mem_be, mem_data} = fifo_empty ? '0 : fifo_head;
    assign mem_addr   = addr_q;
    assign file_size  = file_size_q;
    assign src_id     = src_id_q;
    assign err        = err_q;
    assign frame_done = (state_q == ST_DONE);

    always_comb begin
        state_d     = state_q;
        file_size_d = file_size_q;
        src_id_d    = src_id_q;
        err_d       = err_q;
        addr_d      = addr_q;
        hdr_word    = 1'b0;
        body_word   = 1'b0;
        cnt_base    = byte_cnt_q;
        push_be     = '1;

        if (pop) addr_d = addr_q + ADDR_W'(1);

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    src_id_d    = in_valid[1];
                    err_d       = '0;
                    addr_d      = '0;
                    cnt_base    = '0;
                    file_size_d = '0;
                    hdr_word    = 1'b1;
                    state_d     = ST_HEADER;
                end
            end
            ST_HEADER, ST_BODY: begin
                if (accept) begin
                    if (in_valid[1] != src_id_q) err_d[ERR_SRC] = 1'b1;
                    else if (state_q == ST_HEADER) hdr_word = 1'b1;
                    else body_word = 1'b1;
                end
            end
            ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (hdr_word) begin
            for (int j = 0; j < BPW; j++) begin
                if ((cnt_base + 32'(j) >= 32'(FS_OFS_LO)) && (cnt_base + 32'(j) <= 32'(FS_OFS_HI)))
                    file_size_d[8*(2'(cnt_base + 32'(j) - 32'(FS_OFS_LO))) +: 8] = in_data[8*j +: 8];
            end
        end

        remaining = file_size_q - byte_cnt_q;
        if (body_word) begin
            for (int j = 0; j < BPW; j++) push_be[j] = (remaining > 32'(j));
        end

        push       = (hdr_word || body_word) && !fifo_full;
        cnt_next   = (hdr_word || body_word) ? cnt_base + WORD_BYTES : byte_cnt_q;
        byte_cnt_d = cnt_next;
        target     = frame_target(file_size_d, HDR_LEN);
        hdr_done   = hdr_word && (cnt_next >= HDR_LEN);
        frame_met  = (hdr_done || (state_q == ST_BODY)) && (cnt_next >= target);

        if (hdr_done && (file_size_d < HDR_LEN)) err_d[ERR_HDR] = 1'b1;

        // A header that already covers the whole file has no body to wait for.
        if ((state_q == ST_HEADER) || (state_q == ST_BODY)) begin
            if (frame_met) begin
                state_d = ST_DRAIN;
            end else if (in_cmplt) begin
                err_d[ERR_SHORT] = 1'b1;
                state_d          = ST_DRAIN;
            end else if (hdr_done) begin
                state_d = ST_BODY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= '0;
            file_size_q <= '0;
            src_id_q    <= 1'b0;
            err_q       <= '0;
            addr_q      <= '0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            file_size_q <= file_size_d;
            src_id_q    <= src_id_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            live_q      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bmp_master_sink.sv
// Directed and randomized frames for bmp_master_sink, checked against a
// byte-stream model of the expected memory writes.
module tb_bmp_master_sink;
    localparam int HDR   = 56;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  in_valid = 2'b00;
    logic [31:0] in_data = '0;
    logic        in_cmplt = 1'b0;
    logic        in_ready;
    logic        mem_req;
    logic        mem_gnt;
    logic [15:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_be;
    logic [31:0] file_size;
    logic        src_id;
    logic        frame_done;
    logic [2:0]  err;

    int  n_checks = 0;
    int  n_errors = 0;
    int  done_cnt = 0;
    int  accepted = 0;
    int  stall_cnt = 0;
    bit  gnt_rand = 1'b0;
    bit  block_pending = 1'b0;
    wr_t exp_q[$];
    wr_t obs_q[$];

    bmp_master_sink #(
        .DATA_BUS_SIZE (32),
        .ADDR_W        (16),
        .FIFO_DEPTH    (DEPTH),
        .HDR_BYTES     (HDR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_cmplt   (in_cmplt),
        .in_ready   (in_ready),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_be     (mem_be),
        .file_size  (file_size),
        .src_id     (src_id),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bound_fail(input string tag);
        n_checks++;
        n_errors++;
        $error("FAIL %s: wait bound expired", tag);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ctrl"}, {in_ready, mem_req, src_id, frame_done, err, mem_be}, 64'd0);
        chk({tag, "_addr_data"}, {mem_addr, mem_data}, 64'd0);
        chk({tag, "_fsize"}, file_size, 64'd0);
    endtask

    // Memory-side grant: scripted stall window, otherwise always or random.
    initial begin
        mem_gnt = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (stall_cnt > 0) begin
                mem_gnt = 1'b0;
                stall_cnt--;
            end else begin
                mem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // Write-side monitor: records granted writes and checks request hold.
    initial begin
        bit  prev_req = 1'b0;
        bit  prev_gnt = 1'b0;
        wr_t prev_w   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 1'b0;
            end else begin
                if (prev_req && !prev_gnt)
                    chk("hold_stable", {mem_req, mem_addr, mem_data, mem_be}, {1'b1, prev_w});
                if (mem_req && mem_gnt) obs_q.push_back('{mem_addr, mem_data, mem_be});
                if (frame_done) done_cnt++;
                prev_req = mem_req;
                prev_gnt = mem_gnt;
                prev_w   = '{mem_addr, mem_data, mem_be};
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic s);
        int guard = 0;
        @(negedge clk);
        in_valid = {s, 1'b1};
        in_data  = d;
        while (!in_ready && guard < 200) begin
            if (block_pending && !mem_gnt) begin
                block_pending = 1'b0;
                chk("full_depth", 64'(accepted - obs_q.size()), 64'(DEPTH));
            end
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) bound_fail("send_ready");
        @(posedge clk);
        accepted++;
    endtask

    task automatic frame(input logic [31:0] fs, input int cmplt_after, input int bad_at, input int stall_at);
        wr_t         w;
        logic [31:0] d, target;
        logic [2:0]  exp_err;
        int          n_good, good, guard;
        target  = (fs < HDR) ? 32'(HDR) : fs;
        n_good  = (cmplt_after > 0) ? cmplt_after : int'((target + 3) / 4);
        exp_err = {bad_at >= 0, (cmplt_after > 0) && (32'(4 * cmplt_after) < target), fs < HDR};
        exp_q.delete();
        obs_q.delete();
        done_cnt      = 0;
        accepted      = 0;
        block_pending = (stall_at >= 0);
        good          = 0;
        for (int i = 0; good < n_good; i++) begin
            if (i == stall_at) stall_cnt = 10;
            if (i == bad_at) begin
                send($urandom, 1'b1);
                continue;
            end
            d = $urandom;
            if (good == 0) d[31:16] = fs[15:0];
            if (good == 1) d[15:0]  = fs[31:16];
            w.addr = 16'(good);
            w.data = d;
            for (int j = 0; j < 4; j++)
                w.be[j] = (4 * good + j < HDR) || (32'(4 * good + j) < fs);
            exp_q.push_back(w);
            send(d, 1'b0);
            good++;
        end
        @(negedge clk);
        in_valid = 2'b00;
        in_cmplt = (cmplt_after > 0);
        @(negedge clk);
        in_cmplt = 1'b0;
        guard = 0;
        while (done_cnt == 0 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (done_cnt == 0) bound_fail("frame_done");
        repeat (4) @(negedge clk);
        chk("n_writes", 64'(obs_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
            chk($sformatf("write[%0d]", k), 64'(obs_q[k]), 64'(exp_q[k]));
        chk("file_size", file_size, fs);
        chk("err", err, exp_err);
        chk("src_id", src_id, 1'b0);
        chk("done_pulses", 64'(done_cnt), 64'd1);
        if (block_pending) bound_fail("full_backpressure");
        $display("frame fs=0x%0h writes=%0d err=%b checks=%0d errors=%0d",
                 fs, obs_q.size(), err, n_checks, n_errors);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", in_ready, 1'b1);

        gnt_rand = 1'b0;
        frame(32'h40, 0, -1, -1);
        gnt_rand = 1'b1;
        frame(32'h3A, 0, -1, -1);
        gnt_rand = 1'b0;
        frame(32'h80, 0, -1, 16);
        frame(32'h100, 20, -1, -1);
        gnt_rand = 1'b1;
        frame(32'h60, 0, 10, -1);
        frame(32'h20, 0, -1, -1);
        for (int r = 0; r < 3; r++) frame(32'($urandom_range(57, 200)), 0, -1, -1);

        // Abort a frame with reset after seven words, then run a clean one.
        for (int i = 0; i < 7; i++)
            send((i == 0) ? {16'h0040, 16'($urandom)} : 32'($urandom), 1'b0);
        #3;
        rst_n    = 1'b0;
        in_valid = 2'b00;
        @(negedge clk);
        chk_reset_vals("midreset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_midreset", in_ready, 1'b1);
        gnt_rand = 1'b0;
        frame(32'h40, 0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bmp_master_sink.md
# bmp_master_sink

Downstream stage of the scheduler: consumes the BMP word stream the scheduler presents to master 0 (header words then processed pixel words), applies backpressure through `in_ready`, buffers words in a small FIFO and writes them word by word into an output frame memory. It parses the BMP file size from the header, trims the final partial word with byte enables, tracks the source slave, and reports frame completion and error conditions.

## Interface
- `DATA_BUS_SIZE`, 32, data word width in bits (multiple of 8; 32 is the verified value).
- `ADDR_W`, 16, word-address width of the output memory.
- `FIFO_DEPTH`, 4, buffer depth in words (power of two, ≥2).
- `HDR_BYTES`, 56, header length in bytes forwarded before pixel data.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 2: bit0 = word valid, bit1 = source slave id.
- `in_data` input DATA_BUS_SIZE: stream word, byte 0 in bits [7:0].
- `in_cmplt` input 1: upstream end-of-frame indication (level, sampled each cycle).
- `in_ready` output 1: sink can accept a word this cycle.
- `mem_req` output 1: write request to frame memory.
- `mem_gnt` input 1: memory accepted the write this cycle.
- `mem_addr` output ADDR_W: word address.
- `mem_data` output DATA_BUS_SIZE: write data.
- `mem_be` output DATA_BUS_SIZE/8: byte enables.
- `file_size` output 32: parsed file size in bytes.
- `src_id` output 1: slave id latched from first word of frame.
- `frame_done` output 1: one-cycle pulse at frame end.
- `err` output 3: sticky {err_src, err_short, err_hdr}, cleared at next frame start.

## Operation
- Accept = `in_valid[0] && in_ready`. `in_ready` = state ∈ {IDLE, HEADER, BODY} and FIFO count < FIFO_DEPTH (no simultaneous-pop credit).
- FSM states: IDLE, HEADER, BODY, DRAIN, DONE.
- IDLE: first accept latches `src_id`, clears `err`, `byte_cnt`=0, `mem_addr`=0 → HEADER.
- HEADER: every accepted word pushed with be=all ones, `byte_cnt` += 4. `file_size` = {b5,b4,b3,b2} of the stream: bytes 2,3 of word 0 give [15:0], bytes 0,1 of word 1 give [31:16]. When `byte_cnt` reaches HDR_BYTES → BODY; if `file_size` < HDR_BYTES, set err_hdr and go to BODY with target = HDR_BYTES (no body words accepted).
- BODY: accepted word pushed; remaining = file_size − byte_cnt; if remaining ≥ 4 be=all ones else be=(1<<remaining)−1. When byte_cnt ≥ target after the push → DRAIN.
- Word with `in_valid[1]` ≠ `src_id` mid-frame: not pushed, not counted, err_src set; still acknowledged by `in_ready`.
- `in_cmplt` high in HEADER/BODY before target reached: err_short set → DRAIN.
- DRAIN: `in_ready`=0; wait FIFO empty and no pending request → DONE.
- DONE: `frame_done`=1 for one cycle → IDLE.
- Write side: `mem_req` = FIFO non-empty; `mem_data`/`mem_be` = FIFO head, `mem_addr` = write pointer. On `mem_gnt` pop and `mem_addr` += 1 (wraps at 2^ADDR_W). `mem_gnt` without `mem_req` is ignored.
- `byte_cnt` is 32 bits, compared unsigned.

## Timing
- Reset: `in_ready`=0, `mem_req`=0, `mem_addr`=0, `mem_data`=0, `mem_be`=0, `file_size`=0, `src_id`=0, `frame_done`=0, `err`=0, state IDLE, FIFO empty. `in_ready` rises the first cycle after reset release.
- Latency: word accepted in cycle N drives `mem_req` with its data in cycle N+1 at the earliest.
- `mem_req`, `mem_addr`, `mem_data`, `mem_be` stay stable until the `mem_gnt` cycle.
- Full FIFO: `in_ready` low the cycle the count reaches FIFO_DEPTH; a pop re-raises it the next cycle.
- Push and pop in the same cycle: both take effect, count unchanged.
- `in_cmplt` together with the final accepted word: the word is counted first; err_short only if the target is still unmet.
- Reset mid-frame: everything returns to reset values immediately; FIFO contents are discarded.

## Structure
- Shared package `bmp_pkg`: HDR_BYTES, file-size byte offsets (2..5), FSM state encoding, err bit indices.
- One sub-module: `sync_fifo` (width DATA_BUS_SIZE + DATA_BUS_SIZE/8, depth FIFO_DEPTH, push/pop/full/empty/count).

## Test plan
- file_size=0x40, 16 words, mem_gnt always 1 → writes addr 0..15, all be=0xF, frame_done pulse, err=0.
- file_size=0x3A (58) → 15 writes, last be=0x3, file_size output 0x3A, then frame_done.
- file_size=0x80, mem_gnt low for 10 cycles mid-body → in_ready low after 4 buffered words, all 32 words written in order, no loss.
- file_size=0x100, in_cmplt after 20 words → err=3'b010, 20 writes, frame_done.
- Word with in_valid=2'b11 while src_id=0 → not written, err=3'b100, byte count unchanged.
- Reset asserted after 7 words → outputs at reset values; next frame from addr 0 completes cleanly.
